// File: rtl/id_ex_fwd.sv
// ID->EX pipeline register with operand forwarding and load-use hazard detection.
// Holds one EX slot under valid/ready handshaking and counts the cycles lost to load-use stalls.
module id_ex_fwd #(
    parameter int XLEN  = 32,
    parameter int CTRLW = 64
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic             I_flush,
    input  logic             I_id_valid,
    output logic             O_id_ready,
    input  logic [XLEN-1:0]  I_id_pc,
    input  logic [CTRLW-1:0] I_id_ctrl,
    input  logic [XLEN-1:0]  I_rs1_rdata,
    input  logic [XLEN-1:0]  I_rs2_rdata,
    input  logic [XLEN-1:0]  I_csr_rdata,
    input  logic [1:0]       I_FWDCtrl_rs1,
    input  logic [1:0]       I_FWDCtrl_rs2,
    input  logic [1:0]       I_FWDCtrl_csr,
    input  logic [XLEN-1:0]  I_ls_rd_wdata,
    input  logic [XLEN-1:0]  I_ls_csr_wdata,
    input  logic [XLEN-1:0]  I_wb_rd_wdata,
    input  logic [XLEN-1:0]  I_wb_csr_wdata,
    input  logic             I_ls_is_load,
    input  logic             I_ls_load_done,
    output logic             O_ex_valid,
    input  logic             I_ex_ready,
    output logic [XLEN-1:0]  O_ex_pc,
    output logic [CTRLW-1:0] O_ex_ctrl,
    output logic [XLEN-1:0]  O_ex_rs1,
    output logic [XLEN-1:0]  O_ex_rs2,
    output logic [XLEN-1:0]  O_ex_csr,
    output logic             O_ld_stall,
    output logic [15:0]      O_ld_stall_cnt
);

    localparam logic [1:0] SEL_NOP = 2'd0;
    localparam logic [1:0] SEL_NFW = 2'd1;
    localparam logic [1:0] SEL_LS  = 2'd2;
    localparam logic [1:0] SEL_WB  = 2'd3;

    typedef enum logic {
        EMPTY = 1'b0,
        VALID = 1'b1
    } state_e;

    function automatic logic [XLEN-1:0] resolve_op(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] nfw_data,
        input logic [XLEN-1:0] ls_data,
        input logic [XLEN-1:0] wb_data
    );
        logic [XLEN-1:0] res;
        case (sel)
            SEL_NOP: res = '0;
            SEL_NFW: res = nfw_data;
            SEL_LS:  res = ls_data;
            SEL_WB:  res = wb_data;
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CTRLW-1:0] ctrl_q, ctrl_d;
    logic [XLEN-1:0]  rs1_q, rs1_d;
    logic [XLEN-1:0]  rs2_q, rs2_d;
    logic [XLEN-1:0]  csr_q, csr_d;
    logic             ld_stall_q, ld_stall_d;
    logic [15:0]      stall_cnt_q, stall_cnt_d;

    logic             hazard;
    logic             capture;
    logic             stall_evt;
    logic [XLEN-1:0]  rs1_res, rs2_res, csr_res;

    // Only register-file operands can consume the load result; CSR data from LS is always ready.
    assign hazard = I_id_valid & I_ls_is_load & ~I_ls_load_done &
                    ((I_FWDCtrl_rs1 == SEL_LS) | (I_FWDCtrl_rs2 == SEL_LS));

    assign O_ex_valid = (state_q == VALID);
    assign O_id_ready = ~hazard & ~I_flush & (~O_ex_valid | I_ex_ready);
    assign capture    = I_id_valid & O_id_ready;
    assign stall_evt  = hazard & ~I_flush;

    assign rs1_res = resolve_op(I_FWDCtrl_rs1, I_rs1_rdata, I_ls_rd_wdata,  I_wb_rd_wdata);
    assign rs2_res = resolve_op(I_FWDCtrl_rs2, I_rs2_rdata, I_ls_rd_wdata,  I_wb_rd_wdata);
    assign csr_res = resolve_op(I_FWDCtrl_csr, I_csr_rdata, I_ls_csr_wdata, I_wb_csr_wdata);

    always_comb begin
        state_d = state_q;
        if (I_flush) begin
            state_d = EMPTY;
        end else if (capture) begin
            state_d = VALID;
        end else if (state_q == VALID && I_ex_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload only moves on capture, so a stalled EX slot holds its outputs untouched.
    always_comb begin
        pc_d   = pc_q;
        ctrl_d = ctrl_q;
        rs1_d  = rs1_q;
        rs2_d  = rs2_q;
        csr_d  = csr_q;
        if (capture) begin
            pc_d   = I_id_pc;
            ctrl_d = I_id_ctrl;
            rs1_d  = rs1_res;
            rs2_d  = rs2_res;
            csr_d  = csr_res;
        end
    end

    always_comb begin
        ld_stall_d  = stall_evt;
        stall_cnt_d = stall_evt ? sat_inc16(stall_cnt_q) : stall_cnt_q;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            pc_q        <= '0;
            ctrl_q      <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            csr_q       <= '0;
            ld_stall_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            ctrl_q      <= ctrl_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            csr_q       <= csr_d;
            ld_stall_q  <= ld_stall_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign O_ex_pc        = pc_q;
    assign O_ex_ctrl      = ctrl_q;
    assign O_ex_rs1       = rs1_q;
    assign O_ex_rs2       = rs2_q;
    assign O_ex_csr       = csr_q;
    assign O_ld_stall     = ld_stall_q;
    assign O_ld_stall_cnt = stall_cnt_q;

endmodule
